// File: rtl/alu_arbiter.sv
// Two-port request arbiter sharing one Hack-style ALU; one operation in flight at a time.
// Build option: define ALU_ARB_FIXED_PRI_EN to make port 0 win every tie (no round-robin pointer).
//
// state | meaning
// IDLE  | no operation in flight; req_ready offered to the arbitration winner
// EXEC  | latched operands run through the ALU, result registered
// RESP  | result presented to the granted port until it consumes it
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  input  logic [5:0] ctl0,
  input  logic [5:0] ctl1,
  output logic [1:0] resp_valid,
  input  logic [1:0] resp_ready,
  output logic [7:0] resp_o,
  output logic       resp_zr,
  output logic       resp_ng,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_grant;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic [5:0] r_ctl;
  logic [7:0] r_resp_o;
  logic       r_resp_zr;
  logic       r_resp_ng;

  logic       w_gnt;
  logic       w_accept;
  logic       w_done;
  logic [7:0] w_xa;
  logic [7:0] w_xb;
  logic [7:0] w_ya;
  logic [7:0] w_yb;
  logic [7:0] w_f;
  logic [7:0] w_o;

`ifndef ALU_ARB_FIXED_PRI_EN
  // Port that last completed a response; the other port wins the next tie.
  logic r_ptr;
`endif

  always_comb begin
    w_gnt = req_valid[1];
    if (&req_valid) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      w_gnt = 1'b0;
`else
      w_gnt = ~r_ptr;
`endif
    end
  end

  assign w_accept = (r_state == IDLE) && (|req_valid);
  assign w_done   = (r_state == RESP) && resp_ready[r_grant];

  // ALU: zx/nx on X, zy/ny on Y, f selects add/and, no inverts the result.
  assign w_xa = r_ctl[5] ? 8'h00 : r_x;
  assign w_xb = r_ctl[4] ? ~w_xa : w_xa;
  assign w_ya = r_ctl[3] ? 8'h00 : r_y;
  assign w_yb = r_ctl[2] ? ~w_ya : w_ya;
  assign w_f  = r_ctl[1] ? (w_xb + w_yb) : (w_xb & w_yb);
  assign w_o  = r_ctl[0] ? ~w_f : w_f;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    busy       = (r_state != IDLE);
    if (w_accept) req_ready[w_gnt] = 1'b1;
    if (r_state == RESP) resp_valid[r_grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant   <= 1'b0;
      r_x       <= 8'h00;
      r_y       <= 8'h00;
      r_ctl     <= 6'h00;
      r_resp_o  <= 8'h00;
      r_resp_zr <= 1'b0;
      r_resp_ng <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant <= w_gnt;
        r_x     <= w_gnt ? x1 : x0;
        r_y     <= w_gnt ? y1 : y0;
        r_ctl   <= w_gnt ? ctl1 : ctl0;
      end
      if (r_state == EXEC) begin
        r_resp_o  <= w_o;
        r_resp_zr <= (w_o == 8'h00);
        r_resp_ng <= w_o[7];
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRI_EN
  always_ff @(posedge clk) begin
    if (rst)         r_ptr <= 1'b1;
    else if (w_done) r_ptr <= r_grant;
  end
`endif

  assign resp_o  = r_resp_o;
  assign resp_zr = r_resp_zr;
  assign resp_ng = r_resp_ng;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single-port operations plus
// hand-written sequences for arbitration, backpressure and mid-operation reset.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] x0, y0, x1, y1;
  logic [5:0] ctl0, ctl1;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  logic [7:0] resp_o;
  logic       resp_zr;
  logic       resp_ng;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .ctl0       (ctl0),
    .ctl1       (ctl1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_o     (resp_o),
    .resp_zr    (resp_zr),
    .resp_ng    (resp_ng),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       port;
    logic [7:0] x;
    logic [7:0] y;
    logic [5:0] ctl;
    logic [7:0] exp_o;
    logic       exp_zr;
    logic       exp_ng;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on one port with resp_ready held high; called in IDLE at posedge+1.
  task automatic do_op(input vec_t v);
    logic [1:0] oh;
    oh = v.port ? 2'b10 : 2'b01;
    resp_ready = 2'b11;
    if (v.port) begin
      x1 = v.x; y1 = v.y; ctl1 = v.ctl;
      x0 = ~v.x; y0 = ~v.y; ctl0 = ~v.ctl;
    end else begin
      x0 = v.x; y0 = v.y; ctl0 = v.ctl;
      x1 = ~v.x; y1 = ~v.y; ctl1 = ~v.ctl;
    end
    req_valid = oh;
    #1;
    chk("op_req_ready", req_ready, oh);
    tick();
    req_valid = 2'b00;
    x0 = 8'h00; y0 = 8'h00; x1 = 8'h00; y1 = 8'h00;
    chk("op_exec_busy", busy, 1'b1);
    chk("op_exec_ready", req_ready, 2'b00);
    chk("op_exec_rvalid", resp_valid, 2'b00);
    tick();
    chk("op_resp_valid", resp_valid, oh);
    chk("op_resp_o", resp_o, v.exp_o);
    chk("op_resp_zr", resp_zr, v.exp_zr);
    chk("op_resp_ng", resp_ng, v.exp_ng);
    tick();
    chk("op_idle_busy", busy, 1'b0);
    chk("op_idle_rvalid", resp_valid, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_port;
    logic [7:0] held;

    //            port  x      y      ctl        o      zr    ng
    vecs[0] = '{1'b0, 8'h05, 8'h03, 6'b000010, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h0F, 8'hF0, 6'b000000, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h0F, 8'hF0, 6'b101010, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h0F, 8'hF0, 6'b111010, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h7F, 8'h01, 6'b000010, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h05, 8'h03, 6'b000011, 8'hF7, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h3C, 8'h0F, 6'b000000, 8'h0C, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h10, 8'h03, 6'b010011, 8'h0D, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'hFF, 8'h01, 6'b000010, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    x0 = 8'h00; y0 = 8'h00; x1 = 8'h00; y1 = 8'h00; ctl0 = 6'h00; ctl1 = 6'h00;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid", resp_valid, 2'b00);
    chk("rst_resp_o", resp_o, 8'h00);
    chk("rst_flags", {resp_zr, resp_ng}, 2'b00);
    rst = 1'b0;
    tick();
    chk("idle_no_req_ready", req_ready, 2'b00);
    chk("idle_no_req_busy", busy, 1'b0);

    for (int i = 0; i < 9; i++) do_op(vecs[i]);

    // Continuous ties: round-robin alternates starting with port 0 after reset.
    rst = 1'b1; tick(); rst = 1'b0;
    x0 = 8'h01; y0 = 8'h01; ctl0 = 6'b000010;
    x1 = 8'h20; y1 = 8'h02; ctl1 = 6'b000010;
    resp_ready = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      exp_port = 1'b0;
`else
      exp_port = k[0];
`endif
      #1;
      chk("tie_req_ready", req_ready, exp_port ? 2'b10 : 2'b01);
      tick();
      tick();
      chk("tie_resp_valid", resp_valid, exp_port ? 2'b10 : 2'b01);
      chk("tie_resp_o", resp_o, exp_port ? 8'h22 : 8'h02);
      tick();
    end
    req_valid = 2'b00;
    #1;

    // Backpressure on port 0 while port 1 requests and pulses its resp_ready.
    resp_ready = 2'b00;
    x0 = 8'h21; y0 = 8'h12; ctl0 = 6'b000010;
    x1 = 8'h01; y1 = 8'h02; ctl1 = 6'b000010;
    req_valid = 2'b01;
    #1;
    chk("bp_accept", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    #1;
    chk("bp_exec_ready", req_ready, 2'b00);
    tick();
    chk("bp_resp_valid", resp_valid, 2'b01);
    chk("bp_resp_o", resp_o, 8'h33);
    held = resp_o;
    for (int i = 0; i < 5; i++) begin
      resp_ready = {i[0], 1'b0};
      tick();
      chk("bp_hold_valid", resp_valid, 2'b01);
      chk("bp_hold_o", resp_o, 8'h33);
      chk("bp_hold_stable", resp_o, held);
      chk("bp_hold_ready", req_ready, 2'b00);
      chk("bp_hold_busy", busy, 1'b1);
    end
    resp_ready = 2'b01;
    tick();
    chk("bp_done_busy", busy, 1'b0);
    chk("bp_done_rvalid", resp_valid, 2'b00);
    chk("bp_next_grant", req_ready, 2'b10);
    resp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    tick();
    chk("bp_p1_valid", resp_valid, 2'b10);
    chk("bp_p1_o", resp_o, 8'h03);
    tick();

    // Leave pointer at port 0, then reset in EXEC: pointer must return to port 1.
    do_op(vecs[0]);
    x0 = 8'h05; y0 = 8'h03; ctl0 = 6'b000010;
    x1 = 8'h40; y1 = 8'h40; ctl1 = 6'b000010;
    req_valid = 2'b01;
    tick();
    chk("rst_exec_busy", busy, 1'b1);
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_rvalid", resp_valid, 2'b00);
    chk("rst_mid_o", resp_o, 8'h00);
    chk("rst_mid_tie", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    chk("rst_after_valid", resp_valid, 2'b01);
    chk("rst_after_o", resp_o, 8'h08);
    tick();
    chk("rst_after_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
